// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the dot-product accumulator slice:
//   state_t          - two-state group FSM encoding (ACCUM, DONE)
//   DEFAULT_N_TERMS  - default number of products summed per group
//   DEFAULT_ACC_W    - default accumulator / result width
//   CNT_W            - term counter width (covers N_TERMS up to 255)
//   PROD_W           - width of one 8x8 unsigned product
// ---------------------------------------------------------------------------
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int DEFAULT_N_TERMS = 4;
  localparam int DEFAULT_ACC_W   = 20;
  localparam int CNT_W           = 8;
  localparam int PROD_W          = 16;

endpackage

// File: rtl/dot_product_accumulator_mult.sv
// ---------------------------------------------------------------------------
// Multiplier8x8
// Purely combinational unsigned 8x8 multiplier.
// Ports:
//   A  in  [7:0]   unsigned multiplicand
//   B  in  [7:0]   unsigned multiplier
//   P  out [15:0]  full-width unsigned product A*B
// ---------------------------------------------------------------------------
module Multiplier8x8 (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P
);

  // Both operands are widened first so the product is formed at full width.
  assign P = 16'(A) * 16'(B);

endmodule

// File: rtl/dot_product_accumulator.sv
// ---------------------------------------------------------------------------
// dot_product_accumulator
// Sums groups of unsigned 8x8 products. A group closes after N_TERMS accepted
// terms or on an accepted term flagged in_last, whichever comes first. The
// saturated sum and a sticky overflow flag are then held until the
// downstream consumer takes them.
// Parameters:
//   N_TERMS  products per group (1..255)
//   ACC_W    accumulator / result width (16..32)
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_a/in_b  in   8-bit unsigned operands of the current term
//   in_valid   in   term inputs are valid
//   in_last    in   current term closes the group early
//   in_ready   out  a term is accepted this cycle
//   clear      in   synchronous abort of the partial group (ignored in DONE)
//   out_sum    out  group sum (saturated at 2^ACC_W-1)
//   out_ovf    out  group sum saturated
//   out_valid  out  out_sum/out_ovf hold a completed group
//   out_ready  in   downstream consumes the result
// ---------------------------------------------------------------------------
module dot_product_accumulator
  import mac_pkg::*;
#(
  parameter int N_TERMS = DEFAULT_N_TERMS,
  parameter int ACC_W   = DEFAULT_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               ovf, ovf_next;

  logic [PROD_W-1:0]  product;
  logic [ACC_W:0]     sum_wide;
  logic               accept;
  logic               group_end;

  Multiplier8x8 u_mult (
    .A (in_a),
    .B (in_b),
    .P (product)
  );

  // One extra bit on the adder exposes the carry out, which is exactly the
  // "true sum exceeds the accumulator range" condition used for saturation.
  assign sum_wide = {1'b0, acc} + (ACC_W+1)'(product);

  // A term is only taken in ACCUM; an abort in the same cycle drops it.
  assign accept = (state == ACCUM) && in_valid && !clear;

  // The counter is compared in 9 bits so N_TERMS = 255 still matches after
  // the increment without wrapping.
  assign group_end = accept &&
                     (in_last || (({1'b0, cnt} + 9'd1) == 9'(N_TERMS)));

  // Next-state and output logic: everything holds by default, accepts fold
  // the product in with saturation, and the output handshake returns the
  // block to an empty ACCUM group.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    ovf_next   = ovf;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (clear) begin
          acc_next = '0;
          cnt_next = '0;
          ovf_next = 1'b0;
        end else if (accept) begin
          cnt_next = cnt + 8'd1;
          if (sum_wide[ACC_W]) begin
            acc_next = '1;
            ovf_next = 1'b1;
          end else begin
            acc_next = sum_wide[ACC_W-1:0];
          end
          if (group_end) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          state_next = ACCUM;
        end
      end

      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  // All state lives in this single register process; reset takes effect
  // immediately, independent of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      ovf   <= ovf_next;
    end
  end

  assign out_sum = acc;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_dot_product_accumulator
// Drives a default-width (ACC_W=20) and a narrow (ACC_W=16) accumulator with
// identical stimulus and checks both against hand-derived vectors and a
// group-level reference model.
// ---------------------------------------------------------------------------
module tb_dot_product_accumulator;

  localparam int N_TERMS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_valid;
  logic        in_last;
  logic        clear;
  logic        out_ready;

  logic        in_ready;
  logic [19:0] out_sum;
  logic        out_ovf;
  logic        out_valid;

  logic        in_ready16;
  logic [15:0] out_sum16;
  logic        out_ovf16;
  logic        out_valid16;

  int checks = 0;
  int errors = 0;

  // Reference model: the products of the current group and whether the
  // group has been closed and is waiting for the consumer.
  int unsigned terms[$];
  bit          modelDone;

  typedef struct {
    int     a;
    int     b;
    bit     v;
    bit     l;
    bit     c;
    bit     o;
    bit     er;
    bit     ev;
    longint es;
    bit     eo;
    longint es16;
    bit     eo16;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  dot_product_accumulator #(
    .N_TERMS (N_TERMS),
    .ACC_W   (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .clear     (clear),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  dot_product_accumulator #(
    .N_TERMS (N_TERMS),
    .ACC_W   (16)
  ) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready16),
    .clear     (clear),
    .out_sum   (out_sum16),
    .out_ovf   (out_ovf16),
    .out_valid (out_valid16),
    .out_ready (out_ready)
  );

  function automatic vec_t mkVec(int a, int b, int v, int l, int c, int o,
                                 int er, int ev, longint es, int eo,
                                 longint es16, int eo16);
    vec_t r;
    r.a = a; r.b = b;
    r.v = (v != 0); r.l = (l != 0); r.c = (c != 0); r.o = (o != 0);
    r.er = (er != 0); r.ev = (ev != 0);
    r.es = es; r.eo = (eo != 0);
    r.es16 = es16; r.eo16 = (eo16 != 0);
    return r;
  endfunction

  function automatic longint modelTotal();
    longint s = 0;
    foreach (terms[i]) s += longint'(terms[i]);
    return s;
  endfunction

  function automatic longint modelSum(int w);
    longint mx = (longint'(1) << w) - 1;
    longint t  = modelTotal();
    return (t > mx) ? mx : t;
  endfunction

  function automatic bit modelOvf(int w);
    longint mx = (longint'(1) << w) - 1;
    return modelTotal() > mx;
  endfunction

  // Advance the model by one clock edge using the inputs that were presented.
  task automatic modelStep(int a, int b, bit v, bit l, bit c, bit o);
    if (modelDone) begin
      if (o) begin
        terms.delete();
        modelDone = 1'b0;
      end
    end else if (c) begin
      terms.delete();
    end else if (v) begin
      terms.push_back(int'(a * b));
      if (terms.size() == N_TERMS || l) modelDone = 1'b1;
    end
  endtask

  task automatic checkOne(string name, longint actual, longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(string tag, bit er, bit ev, longint es, bit eo,
                             longint es16, bit eo16);
    checkOne({tag, " in_ready"},    longint'(in_ready),    longint'(er));
    checkOne({tag, " out_valid"},   longint'(out_valid),   longint'(ev));
    checkOne({tag, " out_sum"},     longint'(out_sum),     es);
    checkOne({tag, " out_ovf"},     longint'(out_ovf),     longint'(eo));
    checkOne({tag, " in_ready16"},  longint'(in_ready16),  longint'(er));
    checkOne({tag, " out_valid16"}, longint'(out_valid16), longint'(ev));
    checkOne({tag, " out_sum16"},   longint'(out_sum16),   es16);
    checkOne({tag, " out_ovf16"},   longint'(out_ovf16),   longint'(eo16));
  endtask

  task automatic checkModel(string tag);
    checkOutput(tag, !modelDone, modelDone, modelSum(20), modelOvf(20),
                modelSum(16), modelOvf(16));
  endtask

  // Present one cycle of inputs, let the edge happen, then step the model.
  task automatic applyStimulus(int a, int b, bit v, bit l, bit c, bit o);
    in_a      = a[7:0];
    in_b      = b[7:0];
    in_valid  = v;
    in_last   = l;
    clear     = c;
    out_ready = o;
    @(posedge clk);
    #1;
    modelStep(a, b, v, l, c, o);
  endtask

  // Assert reset mid-cycle and confirm outputs clear without a clock edge.
  task automatic doReset(string tag);
    rst_n = 1'b0;
    #2;
    terms.delete();
    modelDone = 1'b0;
    checkOutput(tag, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    modelDone = 1'b0;
    #7;
    doReset("reset");

    //              a    b   v  l  c  o   rdy val  sum20  ovf  sum16  ovf16
    // Full group of four, then consume.
    vecs.push_back(mkVec(  1,   0, 1, 0, 0, 0,  1, 0,      0, 0,     0, 0));
    vecs.push_back(mkVec(  1,   1, 1, 0, 0, 0,  1, 0,      1, 0,     1, 0));
    vecs.push_back(mkVec(  5,   3, 1, 0, 0, 0,  1, 0,     16, 0,    16, 0));
    vecs.push_back(mkVec(  2,   2, 1, 0, 0, 0,  0, 1,     20, 0,    20, 0));
    vecs.push_back(mkVec(  0,   0, 0, 0, 0, 1,  1, 0,      0, 0,     0, 0));
    // Early close with in_last; narrow instance saturates.
    vecs.push_back(mkVec(255, 255, 1, 0, 0, 0,  1, 0,  65025, 0, 65025, 0));
    vecs.push_back(mkVec(255, 255, 1, 1, 0, 0,  0, 1, 130050, 0, 65535, 1));
    // Backpressure with a held term; clear in DONE is ignored.
    vecs.push_back(mkVec(  3,   3, 1, 0, 0, 0,  0, 1, 130050, 0, 65535, 1));
    vecs.push_back(mkVec(  3,   3, 1, 0, 0, 0,  0, 1, 130050, 0, 65535, 1));
    vecs.push_back(mkVec(  3,   3, 1, 0, 1, 0,  0, 1, 130050, 0, 65535, 1));
    vecs.push_back(mkVec(  3,   3, 1, 0, 0, 1,  1, 0,      0, 0,     0, 0));
    vecs.push_back(mkVec(  3,   3, 1, 0, 0, 0,  1, 0,      9, 0,     9, 0));
    vecs.push_back(mkVec(  0,   0, 0, 0, 1, 0,  1, 0,      0, 0,     0, 0));
    // Abort via clear, with a term presented in the same cycle.
    vecs.push_back(mkVec(  5,   3, 1, 0, 0, 0,  1, 0,     15, 0,    15, 0));
    vecs.push_back(mkVec(  7,   7, 1, 0, 1, 0,  1, 0,      0, 0,     0, 0));
    vecs.push_back(mkVec(  2,   2, 1, 0, 0, 0,  1, 0,      4, 0,     4, 0));
    vecs.push_back(mkVec(  1,   1, 1, 0, 0, 0,  1, 0,      5, 0,     5, 0));
    vecs.push_back(mkVec(  1,   1, 1, 0, 0, 0,  1, 0,      6, 0,     6, 0));
    vecs.push_back(mkVec(  0,   0, 0, 0, 0, 0,  1, 0,      6, 0,     6, 0));
    vecs.push_back(mkVec(  3,   3, 1, 0, 0, 0,  0, 1,     15, 0,    15, 0));
    vecs.push_back(mkVec(  0,   0, 0, 0, 0, 1,  1, 0,      0, 0,     0, 0));
    // Saturation sequence; overflow must not leak into the next group.
    vecs.push_back(mkVec(255, 255, 1, 0, 0, 0,  1, 0,  65025, 0, 65025, 0));
    vecs.push_back(mkVec(255, 255, 1, 0, 0, 0,  1, 0, 130050, 0, 65535, 1));
    vecs.push_back(mkVec(  1,   1, 1, 0, 0, 0,  1, 0, 130051, 0, 65535, 1));
    vecs.push_back(mkVec(  1,   1, 1, 0, 0, 0,  0, 1, 130052, 0, 65535, 1));
    vecs.push_back(mkVec(  0,   0, 0, 0, 0, 1,  1, 0,      0, 0,     0, 0));
    vecs.push_back(mkVec(  2,   3, 1, 0, 0, 0,  1, 0,      6, 0,     6, 0));
    vecs.push_back(mkVec(  0,   0, 0, 0, 1, 0,  1, 0,      0, 0,     0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].v, vecs[i].l, vecs[i].c,
                    vecs[i].o);
      checkOutput($sformatf("vec%0d", i), vecs[i].er, vecs[i].ev, vecs[i].es,
                  vecs[i].eo, vecs[i].es16, vecs[i].eo16);
    end

    // Abort by reset mid-group: the partial group is never emitted.
    applyStimulus(5, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid pre", 1'b1, 1'b0, 15, 1'b0, 15, 1'b0);
    in_valid = 1'b0;
    doReset("rstmid");
    applyStimulus(2, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid t1", 1'b1, 1'b0, 4, 1'b0, 4, 1'b0);
    applyStimulus(1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid t2", 1'b1, 1'b0, 5, 1'b0, 5, 1'b0);
    applyStimulus(1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid t3", 1'b1, 1'b0, 6, 1'b0, 6, 1'b0);
    applyStimulus(3, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid t4", 1'b0, 1'b1, 15, 1'b0, 15, 1'b0);

    // Reset while a result is pending: the result is discarded.
    in_valid = 1'b0;
    doReset("rstdone");
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rstdone idle", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);

    // Randomized traffic against the group-level model.
    for (int n = 0; n < 1500; n++) begin
      int  a;
      int  b;
      bit  v;
      bit  l;
      bit  c;
      bit  o;
      a = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 19) == 0);
      o = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 199) == 0) begin
        doReset($sformatf("rand%0d reset", n));
      end
      applyStimulus(a, b, v, l, c, o);
      checkModel($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
